// File: rtl/store_buffer_if.sv
// store_buffer_if: CPU-side and memory-side signals of the store buffer.
//   addr/rd/wr/wdata  MEM-stage request (held stable by the CPU while stall=1)
//   rdata/stall/idle  load data, pipeline hold, quiescent indication
//   mem_*             single-outstanding handshaked data-memory port
// Modports: slave = store buffer view, master = CPU + memory environment view.
interface store_buffer_if #(
   parameter int AW = 7,
   parameter int DW = 32
);
   logic [AW-1:0] addr;
   logic          rd;
   logic          wr;
   logic [DW-1:0] wdata;
   logic [DW-1:0] rdata;
   logic          stall;
   logic          idle;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_ack;
   logic [DW-1:0] mem_rdata;

   modport slave (
      input  addr, rd, wr, wdata, mem_ack, mem_rdata,
      output rdata, stall, idle, mem_req, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output addr, rd, wr, wdata, mem_ack, mem_rdata,
      input  rdata, stall, idle, mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/store_buffer.sv
// store_buffer: posts MEM-stage stores into a circular FIFO and drains them
// to a slow handshaked memory in the background. Loads hit in the FIFO
// (youngest match) or stall while a memory read is performed.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         store_buffer_if.slave (CPU request side + memory side)
// Parameters: DEPTH (power of two, 2..16), AW word address width, DW data width.
// Optional: define STORE_BUF_COALESCE_EN to let a store overwrite a matching
// buffered entry in place (except the head while it is being drained).
module store_buffer #(
   parameter int DEPTH = 4,
   parameter int AW    = 7,
   parameter int DW    = 32
) (
   input logic           clk,
   input logic           rst_n,
   store_buffer_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {IDLE, WR, RD, RDONE} state_t;

   state_t        state;
   logic [AW-1:0] e_addr [DEPTH];
   logic [DW-1:0] e_data [DEPTH];
   logic [PW-1:0] head, tail;
   logic [CW-1:0] count;
   logic [DW-1:0] rd_cap;

   logic          hit, co_hit, full, load, coal, enq, pop, miss;
   logic [DW-1:0] hit_data, head_data;
   logic [PW-1:0] co_idx;

   // Walk oldest to youngest so the last match seen is the youngest.
   always_comb begin
      hit      = 1'b0;
      hit_data = '0;
      co_hit   = 1'b0;
      co_idx   = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (CW'(k) < count && e_addr[head + PW'(k)] == bus.addr) begin
            hit      = 1'b1;
            hit_data = e_data[head + PW'(k)];
`ifdef STORE_BUF_COALESCE_EN
            // the head is frozen while its write is on the memory bus
            if (!(k == 0 && state == WR)) begin
               co_hit = 1'b1;
               co_idx = head + PW'(k);
            end
`endif
         end
      end
   end

   assign full = (count == CW'(DEPTH));
   assign load = bus.rd && !bus.wr;
   assign coal = bus.wr && co_hit;
   assign enq  = bus.wr && !co_hit && !full;
   assign pop  = (state == WR) && bus.mem_ack;
   assign miss = load && !hit && (state != RDONE);

   assign bus.stall = (bus.wr && !co_hit && full) || miss;
   assign bus.rdata = (load && hit)      ? hit_data :
                      (state == RDONE)   ? rd_cap   : '0;
   assign bus.idle  = (count == '0) && (state == IDLE);

   // A coalesce into the head on the same edge the drain launches must be
   // carried into the transaction, otherwise the new data would be popped unseen.
   assign head_data = (coal && co_idx == head) ? bus.wdata : e_data[head];

   // Entry storage needs no reset: validity comes from head/count.
   always_ff @(posedge clk) begin
      if (enq) begin
         e_addr[tail] <= bus.addr;
         e_data[tail] <= bus.wdata;
      end
      if (coal) e_data[co_idx] <= bus.wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (enq) tail <= tail + PW'(1);
         if (pop) head <= head + PW'(1);
         case ({enq, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Memory-side FSM; every exit from WR/RD passes through a cycle with
   // mem_req low, so back-to-back transactions are always separated.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         bus.mem_req   <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         rd_cap        <= '0;
      end else begin
         case (state)
            IDLE: begin
               // load misses go first; a miss address has no buffered store
               if (miss) begin
                  state        <= RD;
                  bus.mem_req  <= 1'b1;
                  bus.mem_we   <= 1'b0;
                  bus.mem_addr <= bus.addr;
               end else if (count != '0) begin
                  state         <= WR;
                  bus.mem_req   <= 1'b1;
                  bus.mem_we    <= 1'b1;
                  bus.mem_addr  <= e_addr[head];
                  bus.mem_wdata <= head_data;
               end
            end
            WR: begin
               if (bus.mem_ack) begin
                  state       <= IDLE;
                  bus.mem_req <= 1'b0;
               end
            end
            RD: begin
               if (bus.mem_ack) begin
                  state       <= RDONE;
                  bus.mem_req <= 1'b0;
                  rd_cap      <= bus.mem_rdata;
               end
            end
            RDONE:   state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: randomized + directed bench for store_buffer. A queue model
// of buffered stores predicts stall/rdata/idle and the drain order; a memory
// responder acks with programmable latency.
module tb_store_buffer;
   localparam int DEPTH = 4;
   localparam int AW    = 7;
   localparam int DW    = 32;

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } ent_t;

   typedef struct {
      bit            we;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } txn_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   store_buffer_if #(.AW(AW), .DW(DW)) bus ();

   store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int checks = 0;
   int errors = 0;

   // model state
   ent_t          q[$];
   txn_t          log[$];
   bit            rdone = 1'b0;
   bit            ack_prev = 1'b0;
   logic [DW-1:0] rd_ret = '0;
   bit            m_done, m_full;
   int            m_ci;

   // responder controls
   bit            ack_en = 1'b1;
   int            lat = 0;
   bit            fixed = 1'b0;
   logic [DW-1:0] rdval = '0;
   int            cnt = 0;

   task automatic check1(input string name, input bit act, input bit exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out at %0t", name, $time);
   endtask

   function automatic bit q_lookup(input logic [AW-1:0] a, output logic [DW-1:0] d);
      bit h = 1'b0;
      d = '0;
      foreach (q[i]) if (q[i].a == a) begin h = 1'b1; d = q[i].d; end
      return h;
   endfunction

   function automatic int co_find(input logic [AW-1:0] a, input bit draining);
      int r = -1;
      foreach (q[i]) if (q[i].a == a && !(i == 0 && draining)) r = i;
      return r;
   endfunction

   // memory responder: ack once mem_req has been seen for more than lat cycles
   initial begin
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         bus.mem_ack = 1'b0;
         if (!rst_n) cnt = 0;
         else if (bus.mem_req) begin
            cnt++;
            if (ack_en && cnt > lat) begin
               bus.mem_ack   = 1'b1;
               bus.mem_rdata = fixed ? rdval : $urandom;
               cnt = 0;
            end
         end else cnt = 0;
      end
   end

   // model update on each edge from the values seen just before it
   always @(posedge clk) begin
      if (!rst_n) begin
         q.delete();
         rdone    = 1'b0;
         ack_prev = 1'b0;
      end else begin
         m_done = bus.mem_req && bus.mem_ack;
         m_full = (q.size() == DEPTH);
         m_ci   = -1;
`ifdef STORE_BUF_COALESCE_EN
         if (bus.wr) m_ci = co_find(bus.addr, bus.mem_req && bus.mem_we);
`endif
         if (m_done) begin
            log.push_back('{we: bus.mem_we, a: bus.mem_addr,
                            d: bus.mem_we ? bus.mem_wdata : bus.mem_rdata});
            if (bus.mem_we && q.size() > 0) void'(q.pop_front());
            if (!bus.mem_we) rd_ret = bus.mem_rdata;
         end
         rdone = m_done && !bus.mem_we;
         if (bus.wr) begin
            if (m_ci >= 0) begin
               if (m_done && bus.mem_we) m_ci--;
               q[m_ci].d = bus.wdata;
            end else if (!m_full) q.push_back('{a: bus.addr, d: bus.wdata});
         end
         ack_prev = m_done;
      end
   end

   // per-cycle comparison against the model
   always @(negedge clk) begin : cmp
      logic [DW-1:0] hd;
      bit h, es;
      if (rst_n) begin
         h = q_lookup(bus.addr, hd);
         if (bus.wr) begin
            es = (q.size() == DEPTH);
`ifdef STORE_BUF_COALESCE_EN
            if (co_find(bus.addr, bus.mem_req && bus.mem_we) >= 0) es = 1'b0;
`endif
            check1("stall_wr", bus.stall, es);
         end else if (bus.rd) begin
            if (rdone) begin
               check1("stall_rdone", bus.stall, 1'b0);
               check32("rdata_rdone", bus.rdata, rd_ret);
            end else if (h) begin
               check1("stall_hit", bus.stall, 1'b0);
               check32("rdata_hit", bus.rdata, hd);
            end else begin
               check1("stall_miss", bus.stall, 1'b1);
               check32("rdata_miss", bus.rdata, 32'h0);
            end
         end else check1("stall_nop", bus.stall, 1'b0);
         check1("idle", bus.idle, q.size() == 0 && !bus.mem_req && !rdone);
         if (ack_prev) check1("req_gap", bus.mem_req, 1'b0);
         if (bus.mem_req) begin
            if (bus.mem_we) begin
               if (q.size() == 0) timeout("drain_with_empty_model");
               else begin
                  check32("drain_addr", 32'(bus.mem_addr), 32'(q[0].a));
                  check32("drain_data", bus.mem_wdata, q[0].d);
               end
            end else begin
               check32("read_addr", 32'(bus.mem_addr), 32'(bus.addr));
               check1("read_only_on_miss", h, 1'b0);
            end
         end
      end
   end

   task automatic cpu_set(input bit w, input bit r, input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.wr = w; bus.rd = r; bus.addr = a; bus.wdata = d;
   endtask

   // wait for acceptance (stall low), then drop the request after the edge
   task automatic cpu_wait();
      int n = 0;
      @(negedge clk);
      while (bus.stall && n < 200) begin n++; @(negedge clk); end
      if (n >= 200) timeout("cpu_accept");
      @(posedge clk);
      #1;
      bus.wr = 1'b0; bus.rd = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (!bus.idle && n < 200) begin n++; @(negedge clk); end
      if (n >= 200) timeout("wait_idle");
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      cpu_set(1'b0, 1'b0, '0, '0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // reset state
      @(negedge clk);
      check1("rst_mem_req", bus.mem_req, 1'b0);
      check1("rst_mem_we", bus.mem_we, 1'b0);
      check32("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
      check32("rst_mem_wdata", bus.mem_wdata, 32'h0);
      check32("rst_rdata", bus.rdata, 32'h0);
      check1("rst_idle", bus.idle, 1'b1);
      @(posedge clk); #1;

      // reset while a drain is on the bus
      ack_en = 1'b0;
      cpu_set(1'b1, 1'b0, 7'd3, 32'h11); cpu_wait();
      n = 0;
      @(negedge clk);
      while (!bus.mem_req && n < 20) begin n++; @(negedge clk); end
      if (n >= 20) timeout("drain_start");
      rst_n = 1'b0;
      #1;
      check1("midrst_mem_req", bus.mem_req, 1'b0);
      check1("midrst_idle", bus.idle, 1'b1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      ack_en = 1'b1;
      log.delete();
      repeat (10) @(negedge clk);
      check32("midrst_no_write", log.size(), 0);
      @(posedge clk); #1;

      // fill to DEPTH, fifth store stalls until the first pop
      ack_en = 1'b0; lat = 0; log.delete();
      for (int i = 1; i <= 4; i++) begin
         cpu_set(1'b1, 1'b0, AW'(i), 32'hA0 + 32'(i)); cpu_wait();
      end
      cpu_set(1'b1, 1'b0, 7'd5, 32'hA5);
      repeat (3) begin @(negedge clk); check1("fill_stall", bus.stall, 1'b1); end
      ack_en = 1'b1;
      @(negedge clk); check1("fill_stall_ack_cycle", bus.stall, 1'b1);
      @(negedge clk); check1("fill_admit", bus.stall, 1'b0);
      @(posedge clk); #1; bus.wr = 1'b0;
      wait_idle();
      check32("fill_nwrites", log.size(), 5);
      foreach (log[i]) begin
         check32("fill_order_addr", 32'(log[i].a), 32'(i + 1));
         check32("fill_order_data", log[i].d, 32'hA1 + 32'(i));
      end

      // load hit returns youngest entry
      ack_en = 1'b0;
      cpu_set(1'b1, 1'b0, 7'd7, 32'h1); cpu_wait();
      cpu_set(1'b1, 1'b0, 7'd7, 32'h2); cpu_wait();
      cpu_set(1'b0, 1'b1, 7'd7, '0);
      @(negedge clk);
      check32("hit_youngest", bus.rdata, 32'h2);
      check1("hit_nostall", bus.stall, 1'b0);
      check1("hit_no_read", bus.mem_req && !bus.mem_we, 1'b0);
      @(posedge clk); #1; bus.rd = 1'b0;
      ack_en = 1'b1;
      wait_idle();

      // load miss
      lat = 2; fixed = 1'b1; rdval = 32'hDEADBEEF;
      cpu_set(1'b0, 1'b1, 7'd9, '0);
      n = 0;
      @(negedge clk);
      while (bus.stall && n < 50) begin n++; @(negedge clk); end
      check32("miss_stall_cycles", n, 4);
      check32("miss_rdata", bus.rdata, 32'hDEADBEEF);
      check1("miss_done_nostall", bus.stall, 1'b0);
      @(posedge clk); #1; bus.rd = 1'b0;
      fixed = 1'b0; lat = 0;
      wait_idle();

      // load miss has priority over draining
      ack_en = 1'b0; log.delete();
      cpu_set(1'b1, 1'b0, 7'd30, 32'h30); cpu_wait();
      cpu_set(1'b1, 1'b0, 7'd31, 32'h31); cpu_wait();
      cpu_set(1'b1, 1'b0, 7'd32, 32'h32); cpu_wait();
      cpu_set(1'b0, 1'b1, 7'd20, '0);
      @(negedge clk);
      ack_en = 1'b1;
      n = 0;
      while (bus.stall && n < 100) begin n++; @(negedge clk); end
      if (n >= 100) timeout("prio_read");
      @(posedge clk); #1; bus.rd = 1'b0;
      wait_idle();
      check32("prio_ntxn", log.size(), 4);
      if (log.size() == 4) begin
         check32("prio_t0", {log[0].we, 7'(log[0].a)}, {1'b1, 7'd30});
         check32("prio_t1", {log[1].we, 7'(log[1].a)}, {1'b0, 7'd20});
         check32("prio_t2", {log[2].we, 7'(log[2].a)}, {1'b1, 7'd31});
         check32("prio_t3", {log[3].we, 7'(log[3].a)}, {1'b1, 7'd32});
      end

`ifdef STORE_BUF_COALESCE_EN
      // coalescing into a full buffer
      ack_en = 1'b0; log.delete();
      for (int i = 1; i <= 4; i++) begin
         cpu_set(1'b1, 1'b0, AW'(i), 32'hB0 + 32'(i)); cpu_wait();
      end
      cpu_set(1'b1, 1'b0, 7'd3, 32'h55);
      @(negedge clk);
      check1("coal_nostall", bus.stall, 1'b0);
      @(posedge clk); #1; bus.wr = 1'b0;
      ack_en = 1'b1;
      wait_idle();
      check32("coal_nwrites", log.size(), 4);
      if (log.size() == 4) check32("coal_data", log[2].d, 32'h55);
`endif

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         int op;
         logic [AW-1:0] a;
         lat = $urandom_range(0, 3);
         op  = $urandom_range(0, 9);
         a   = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(8, 127)) : AW'($urandom_range(0, 7));
         case (op)
            0, 1, 2, 3: cpu_set(1'b1, 1'b0, a, $urandom);
            4, 5, 6, 7: cpu_set(1'b0, 1'b1, a, '0);
            8:          cpu_set(1'b1, 1'b1, a, $urandom);
            default:    cpu_set(1'b0, 1'b0, a, '0);
         endcase
         cpu_wait();
      end
      lat = 0;
      wait_idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
